// File: rtl/disp7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp7seg_scan_ctrl
//  Description : Multiplexed scan controller for an NDIG-digit 7-segment
//                display. One digit per clocken tick, an all-anodes-off guard
//                interval after every digit change, a double-buffered value
//                that swaps only at frame wrap, hex decode and optional
//                leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module disp7seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int BLANK_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clocken,
  input  logic              enable,
  input  logic              lz_en,
  input  logic              load,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] data_in,
  input  logic [NDIG-1:0]   dp_in,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_tick
);

  localparam int                c_IW         = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int                c_CW         = $clog2(BLANK_CYC + 1);
  localparam logic [c_IW-1:0]   c_IDX_LAST   = c_IW'(NDIG - 1);
  localparam logic [c_CW-1:0]   c_BLANK_LAST = c_CW'(BLANK_CYC - 1);
  localparam logic [NDIG-1:0]   c_ONE        = NDIG'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_IW-1:0]   r_idx, w_idx_nxt;
  logic [c_CW-1:0]   r_bcnt, w_bcnt_nxt;
  logic              w_wrap;

  logic [4*NDIG-1:0] r_disp, r_pend;
  logic [NDIG-1:0]   r_disp_dp, r_pend_dp;
  logic              r_pend_valid;
  logic              w_take, w_xfer;

  logic [3:0]        w_nib;
  logic [6:0]        w_seg_dec;
  logic [NDIG-1:0]   w_hi_zero;
  logic              w_lz_blank;
  logic [NDIG-1:0]   w_an_sel;

  logic [NDIG-1:0]   r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic              r_frame_tick;

  // State, digit index and guard counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Next-state logic: enable low wins everywhere; clocken only matters in SHOW
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bcnt_nxt  = r_bcnt;
    w_wrap      = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_bcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = '0;
          w_bcnt_nxt  = '0;
        end
        S_BLANK: begin
          if (r_bcnt == c_BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (clocken) begin
            w_state_nxt = S_BLANK;
            w_bcnt_nxt  = '0;
            if (r_idx == c_IDX_LAST) begin
              w_idx_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A load can only be taken while the pending slot is empty, and a transfer
  // needs a full slot, so the two are mutually exclusive by construction.
  assign w_take     = load & ~r_pend_valid;
  assign w_xfer     = r_pend_valid & (w_wrap | (r_state == S_IDLE));
  assign load_ready = ~r_pend_valid;

  // Pending and display buffers with the load handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
      r_disp_dp    <= '0;
    end else if (w_take) begin
      r_pend       <= data_in;
      r_pend_dp    <= dp_in;
      r_pend_valid <= 1'b1;
    end else if (w_xfer) begin
      r_disp       <= r_pend;
      r_disp_dp    <= r_pend_dp;
      r_pend_valid <= 1'b0;
    end
  end

  // Per digit: are this nibble and every more significant nibble zero?
  for (genvar k = 0; k < NDIG; k++) begin : g_lz
    assign w_hi_zero[k] = (r_disp[4*NDIG-1:4*k] == '0);
  end

  assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];
  assign w_lz_blank = lz_en & (r_idx != '0) & w_hi_zero[r_idx];
  assign w_an_sel   = ~(c_ONE << r_idx);

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // Registered outputs, one clock behind the scan state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (r_state == S_SHOW) begin
        r_an  <= w_an_sel;
        r_seg <= w_lz_blank ? 7'h7F : w_seg_dec;
        r_dp  <= ~r_disp_dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp7seg_scan_ctrl
//  Description : Self-checking bench for disp7seg_scan_ctrl: a 4-digit
//                instance against a behavioural model plus a table of decode
//                vectors and directed sequences, and a 3-digit instance for
//                the non-power-of-2 wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disp7seg_scan_ctrl;

  localparam int BLANK = 16;

  logic        clock;
  logic        reset, enable, lz_en, load, load_ready;
  logic        clocken, auto_ck, man_ck, ack;
  int          ack_cnt;
  logic [15:0] data_in;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;
  logic        dp, frame_tick;

  logic        en3, ck3, lz3, load3, lr3, dp3, ft3;
  logic [11:0] data3;
  logic [2:0]  dpi3, an3;
  logic [6:0]  seg3;

  int n_chk, n_err;
  logic chk_on;

  disp7seg_scan_ctrl #(.NDIG(4), .BLANK_CYC(BLANK)) u_dut (
    .clock(clock), .reset(reset), .clocken(clocken), .enable(enable),
    .lz_en(lz_en), .load(load), .load_ready(load_ready), .data_in(data_in),
    .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  disp7seg_scan_ctrl #(.NDIG(3), .BLANK_CYC(3)) u_dut3 (
    .clock(clock), .reset(reset), .clocken(ck3), .enable(en3),
    .lz_en(lz3), .load(load3), .load_ready(lr3), .data_in(data3),
    .dp_in(dpi3), .an(an3), .seg(seg3), .dp(dp3), .frame_tick(ft3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Free-running scan tick, one pulse every 40 clocks
  always @(negedge clock) begin
    ack_cnt <= (ack_cnt >= 39) ? 0 : ack_cnt + 1;
    ack     <= (ack_cnt == 0);
  end
  assign clocken = auto_ck ? ack : man_ck;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------- behavioural reference model (4-digit instance) --------
  // m_on: scanning; m_bl: guard clocks still to go (0 = digit lit);
  // m_dig: digit being scanned. Expected outputs are taken from the state
  // before each edge, which gives the one-clock output lag.
  logic        m_on, m_pv, m_wrap;
  int          m_dig, m_bl;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp, m_nib;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft, e_lr;

  always @(posedge clock) begin
    if (reset) begin
      m_on = 1'b0; m_pv = 1'b0; m_dig = 0; m_bl = 0;
      m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      m_wrap = m_on && (m_bl == 0) && clocken && enable && (m_dig == 3);
      if (m_on && m_bl == 0) begin
        e_an = 4'hF;
        e_an[m_dig] = 1'b0;
        m_nib = 4'((m_disp >> (4 * m_dig)) & 16'hF);
        if (lz_en && m_dig > 0 && (m_disp >> (4 * m_dig)) == 16'h0) e_seg = 7'h7F;
        else e_seg = seg_of(m_nib);
        e_dp = ~m_ddp[m_dig];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_ft = m_wrap;
      if (load && !m_pv) begin
        m_pend = data_in; m_pdp = dp_in; m_pv = 1'b1;
      end else if (m_pv && (m_wrap || !m_on)) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0;
      end
      if (!enable) begin
        m_on = 1'b0; m_dig = 0; m_bl = 0;
      end else if (!m_on) begin
        m_on = 1'b1; m_dig = 0; m_bl = BLANK;
      end else if (m_bl > 0) begin
        m_bl = m_bl - 1;
      end else if (clocken) begin
        m_dig = (m_dig + 1) % 4; m_bl = BLANK;
      end
    end
    e_lr = ~m_pv;
  end

  // Advance one clock; compare the 4-digit instance with the model
  task automatic cyc();
    @(negedge clock);
    if (chk_on) begin
      n_chk++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp ||
          frame_tick !== e_ft || load_ready !== e_lr) begin
        n_err++;
        $display("FAIL model @%0t got/want an=%b/%b seg=%b/%b dp=%b/%b ft=%b/%b lr=%b/%b",
                 $time, an, e_an, seg, e_seg, dp, e_dp, frame_tick, e_ft, load_ready, e_lr);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string nm);
    int n = 0;
    while (an !== tgt && n < 400) begin cyc(); n++; end
    chk({nm, "_reached"}, {28'd0, an}, {28'd0, tgt});
  endtask

  task automatic wait_ft(output logic lr_before);
    int n = 0;
    lr_before = load_ready;
    cyc();
    while (frame_tick !== 1'b1 && n < 600) begin lr_before = load_ready; cyc(); n++; end
    chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic        lz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t        tbl [8];
  logic        lr_b;
  logic [3:0]  tgt;
  logic [2:0]  one3, tgt3;
  logic [6:0]  exp_s;
  logic [31:0] rnd;
  int          n, nft;

  initial begin
    tbl[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
    tbl[3] = '{16'h3456, 4'b0000, 1'b0, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
    tbl[4] = '{16'h789B, 4'b0000, 1'b1, {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}};
    tbl[5] = '{16'hCDE0, 4'b0101, 1'b1, {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}};
    tbl[6] = '{16'h0000, 4'b1010, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    tbl[7] = '{16'h0100, 4'b1000, 1'b1, {7'h7F, 7'b1111001, 7'b1000000, 7'b1000000}};

    n_chk = 0; n_err = 0; chk_on = 1'b0;
    reset = 1'b1; enable = 1'b0; lz_en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    auto_ck = 1'b0; man_ck = 1'b0; ack_cnt = 0; ack = 1'b0;
    en3 = 1'b0; ck3 = 1'b0; lz3 = 1'b0; load3 = 1'b0; data3 = '0; dpi3 = '0;
    one3 = 3'b001;
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_ft", {31'd0, frame_tick}, 32'd0);
    chk("rst_lr", {31'd0, load_ready}, 32'd1);
    chk_on = 1'b1;

    // Decode vectors: load, wait for the frame swap, then read one frame
    enable = 1'b1; auto_ck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lz_en = tbl[i].lz;
      n = 0;
      while (load_ready !== 1'b1 && n < 600) begin cyc(); n++; end
      data_in = tbl[i].data; dp_in = tbl[i].dpv; load = 1'b1;
      cyc();
      load = 1'b0;
      wait_ft(lr_b);
      for (int d = 0; d < 4; d++) begin
        tgt = ~(4'b0001 << d);
        wait_an(tgt, "tbl_an");
        exp_s = tbl[i].segs[7*d +: 7];
        chk($sformatf("tbl%0d_seg%0d", i, d), {25'd0, seg}, {25'd0, exp_s});
        chk($sformatf("tbl%0d_dp%0d", i, d), {31'd0, dp}, {31'd0, ~tbl[i].dpv[d]});
        if (i == 0 && d == 0) begin
          n = 0;
          while (an === 4'b1110 && n < 400) begin cyc(); n++; end
          n = 0;
          while (an === 4'b1111 && n < 400) begin cyc(); n++; end
          chk("guard_len", n, BLANK);
          chk("guard_next", {28'd0, an}, 32'hD);
        end
      end
    end

    // Second load while busy is dropped; swap only at the frame tick
    wait_an(4'b1101, "t2_mid");
    chk("t2_ready", {31'd0, load_ready}, 32'd1);
    data_in = 16'h0000; dp_in = 4'h0; load = 1'b1;
    cyc();
    data_in = 16'h1234;
    chk("t2_busy", {31'd0, load_ready}, 32'd0);
    cyc();
    load = 1'b0;
    wait_an(4'b1011, "t2_old");
    chk("t2_old_seg", {25'd0, seg}, 32'b1111001);
    wait_ft(lr_b);
    chk("t2_lr_before", {31'd0, lr_b}, 32'd0);
    chk("t2_lr_after", {31'd0, load_ready}, 32'd1);
    lz_en = 1'b0;
    wait_an(4'b1110, "t2_new");
    chk("t2_new_seg", {25'd0, seg}, 32'b1000000);

    // Enable dropped in SHOW; load while dark; re-enable
    wait_an(4'b1101, "t4_show");
    enable = 1'b0;
    cyc();
    chk("t4_lag", {28'd0, an}, 32'hD);
    cyc();
    chk("t4_dark", {28'd0, an}, 32'hF);
    chk("t4_dark_seg", {25'd0, seg}, 32'h7F);
    data_in = 16'h00A5; dp_in = 4'h0; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("t4_busy", {31'd0, load_ready}, 32'd0);
    cyc();
    chk("t4_xfer", {31'd0, load_ready}, 32'd1);
    enable = 1'b1;
    cyc();
    n = 0;
    while (an === 4'hF && n < 100) begin n++; cyc(); end
    chk("t4_guard", n, BLANK + 1);
    chk("t4_digit0", {28'd0, an}, 32'hE);
    chk("t4_seg", {25'd0, seg}, 32'b0010010);

    // Reset in the guard interval with a load pending
    wait_an(4'b1101, "t5_show");
    n = 0;
    while (an !== 4'hF && n < 400) begin cyc(); n++; end
    cyc(); cyc();
    data_in = 16'h5555; dp_in = 4'hF; load = 1'b1;
    cyc();
    load = 1'b0; reset = 1'b1;
    chk("t5_pending", {31'd0, load_ready}, 32'd0);
    cyc();
    reset = 1'b0;
    chk("t5_an", {28'd0, an}, 32'hF);
    chk("t5_seg", {25'd0, seg}, 32'h7F);
    chk("t5_dp", {31'd0, dp}, 32'd1);
    chk("t5_ft", {31'd0, frame_tick}, 32'd0);
    chk("t5_lr", {31'd0, load_ready}, 32'd1);
    wait_an(4'b1110, "t5_scan");
    chk("t5_discard", {25'd0, seg}, 32'b1000000);

    // Three-digit wrap; extra ticks inside the guard interval are ignored
    data3 = 12'h210; load3 = 1'b1;
    cyc();
    load3 = 1'b0;
    cyc();
    en3 = 1'b1;
    nft = 0;
    for (int k = 0; k < 7; k++) begin
      n = 0;
      while (an3 === 3'b111 && n < 100) begin n++; cyc(); end
      tgt3 = ~(one3 << (k % 3));
      chk($sformatf("t6_an%0d", k), {29'd0, an3}, {29'd0, tgt3});
      chk($sformatf("t6_seg%0d", k), {25'd0, seg3}, {25'd0, seg_of(4'(k % 3))});
      ck3 = 1'b1;
      cyc();
      chk($sformatf("t6_ft%0d", k), {31'd0, ft3}, {31'd0, (k % 3) == 2});
      if (ft3 === 1'b1) nft++;
      cyc();
      ck3 = 1'b0;
      chk($sformatf("t6_ft_pulse%0d", k), {31'd0, ft3}, 32'd0);
    end
    chk("t6_frames", nft, 2);

    // Randomized traffic against the model
    auto_ck = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      man_ck = ($urandom_range(0, 4) == 0);
      load = ($urandom_range(0, 2) == 0);
      rnd = $urandom;
      data_in = 16'(rnd >> $urandom_range(16, 32));
      dp_in = 4'($urandom);
      reset = ($urandom_range(0, 1499) == 0);
    end
    reset = 1'b0; load = 1'b0; man_ck = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
